// File: rtl/divider_1hz.sv
// Clock-enable divider: counts enabled clk_i cycles modulo DivRatio and drives an
// active-low registered strobe, either a one-cycle tick or a near-50 % square wave.
module divider_1hz #(
  parameter int unsigned DivRatio = 50_000_000,
  parameter int unsigned OutMode  = 0
) (
  input  logic clk_i,
  input  logic enable_i,
  input  logic rst_i,
  output logic sig_1hz_no
);

  localparam int unsigned CntW     = (DivRatio <= 1) ? 1 : $clog2(DivRatio);
  localparam logic [CntW-1:0] LastCnt = CntW'(DivRatio - 1);
  // Computed at 33 bits so DivRatio = 2^32-1 cannot overflow the rounding add.
  localparam logic [32:0] HighLen  = ({1'b0, DivRatio} + 33'd1) >> 1;

  if (DivRatio < 1) begin : g_err_ratio
    $error("divider_1hz: DivRatio must be at least 1");
  end
  if (OutMode > 1) begin : g_err_mode
    $error("divider_1hz: OutMode must be 0 (pulse) or 1 (square)");
  end
  if (OutMode == 1 && DivRatio < 2) begin : g_err_square
    $error("divider_1hz: square mode needs DivRatio of at least 2");
  end

  logic [CntW-1:0] cnt;
  logic [CntW-1:0] next_cnt;
  logic            at_last;

  always_comb begin
    at_last  = (cnt == LastCnt);
    next_cnt = at_last ? '0 : cnt + CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt        <= '0;
      sig_1hz_no <= 1'b1;
    end else if (enable_i) begin
      cnt <= next_cnt;
      if (OutMode == 0) begin
        sig_1hz_no <= ~at_last;
      end else begin
        sig_1hz_no <= (33'(next_cnt) < HighLen);
      end
    end else if (OutMode == 0) begin
      // A tick never outlives its cycle, even when enable drops right after it.
      sig_1hz_no <= 1'b1;
    end
  end

endmodule

// File: tb/tb_divider_1hz.sv
// Directed bench for divider_1hz: four instances (pulse /5, pulse /1, square /5,
// square /4) share one stimulus; expectations are queued per edge and compared after it.
module tb_divider_1hz;

  logic clk;
  logic rst;
  logic en;
  logic out_p5, out_p1, out_s5, out_s4;

  divider_1hz #(.DivRatio(5), .OutMode(0)) u_p5 (.clk_i(clk), .enable_i(en), .rst_i(rst), .sig_1hz_no(out_p5));
  divider_1hz #(.DivRatio(1), .OutMode(0)) u_p1 (.clk_i(clk), .enable_i(en), .rst_i(rst), .sig_1hz_no(out_p1));
  divider_1hz #(.DivRatio(5), .OutMode(1)) u_s5 (.clk_i(clk), .enable_i(en), .rst_i(rst), .sig_1hz_no(out_s5));
  divider_1hz #(.DivRatio(4), .OutMode(1)) u_s4 (.clk_i(clk), .enable_i(en), .rst_i(rst), .sig_1hz_no(out_s4));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic       p5;
    logic       p1;
    logic       s5;
    logic       s4;
    logic [2:0] cnt5;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: count of enabled edges since reset, plus held square levels.
  int   n_en = 0;
  logic s5_lvl = 1'b1;
  logic s4_lvl = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en_v, input logic rst_v);
    exp_t e;
    en  = en_v;
    rst = rst_v;
    if (rst_v) begin
      n_en   = 0;
      s5_lvl = 1'b1;
      s4_lvl = 1'b1;
      e.p5 = 1'b1;
      e.p1 = 1'b1;
    end else if (en_v) begin
      n_en++;
      s5_lvl = ((n_en % 5) < 3);
      s4_lvl = ((n_en % 4) < 2);
      e.p5 = ((n_en % 5) != 0);
      e.p1 = 1'b0;
    end else begin
      e.p5 = 1'b1;
      e.p1 = 1'b1;
    end
    e.s5   = s5_lvl;
    e.s4   = s4_lvl;
    e.cnt5 = 3'(n_en % 5);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("pulse5_out",  32'(out_p5),    32'(e.p5));
    chk("pulse1_out",  32'(out_p1),    32'(e.p1));
    chk("square5_out", 32'(out_s5),    32'(e.s5));
    chk("square4_out", 32'(out_s4),    32'(e.s4));
    chk("pulse5_cnt",  32'(u_p5.cnt),  32'(e.cnt5));
  endtask

  initial begin
    en  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset hold with enable both high and low.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);

    // Released but disabled: nothing moves.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

    // Free-running: ticks after enabled edges 5 and 10.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);

    // Fixed-value spot check: after 12 enabled edges /5 counter sits at 2.
    chk("pulse5_cnt_after12", 32'(u_p5.cnt), 32'd2);

    // Enable gap of 3 cycles mid-period.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);

    // Advance to cnt==3, then a single-cycle reset with enable high.
    for (int i = 0; i < 10; i++) begin
      if ((n_en % 5) == 3) break;
      step(1'b1, 1'b0);
    end
    chk("pulse5_cnt_before_rst", 32'(u_p5.cnt), 32'd3);
    step(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);

    // Enable toggling every cycle.
    for (int i = 0; i < 14; i++) step(1'(i % 2), 1'b0);

    // Reset landing on a tick cycle ends the tick at that edge.
    for (int i = 0; i < 10; i++) begin
      if ((n_en % 5) == 4) break;
      step(1'b1, 1'b0);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
